// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/(ROR) unit, up to STEP bits per clock.
// Ports: clk, rst (sync, active-high), start/op/shamt/X in; ready/done/result out.
// Optional rotate-right support for op=11 is enabled by defining SEQ_SHIFTER_ROR_EN.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         X,
  output logic                     ready,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so STEP==WIDTH and WIDTH itself are representable.
  localparam logic [SHW:0]       STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0]       WIDTH_W = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0]   ONES    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;

  logic [SHW:0]     rem_w;
  logic [SHW:0]     s;
  logic [WIDTH-1:0] shifted;
  logic             illegal;

  assign rem_w = {1'b0, rem_q};
  assign s     = (rem_w > STEP_W) ? STEP_W : rem_w;

`ifdef SEQ_SHIFTER_ROR_EN
  assign illegal = 1'b0;
`else
  // Without rotate support op=11 degenerates to a zero-length shift.
  assign illegal = (op == 2'b11);
`endif

  always_comb begin
    shifted = work_q;
    case (op_q)
      2'b00: shifted = work_q << s;
      2'b01: shifted = work_q >> s;
      // Fill uses the sign captured at accept, not the evolving work reg.
      2'b10: shifted = (work_q >> s) | (sign_q ? ~(ONES >> s) : '0);
`ifdef SEQ_SHIFTER_ROR_EN
      2'b11: shifted = (work_q >> s) | (work_q << (WIDTH_W - s));
`endif
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = X;
          op_d   = op;
          rem_d  = shamt;
          sign_d = X[WIDTH-1];
          if (shamt == '0 || illegal) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = X;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = SHW'(rem_w - s);
        if (rem_w <= STEP_W) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = shifted;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed + random checks of seq_shifter (WIDTH=32, STEP=4)
// against an arithmetic reference for result and done latency.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] x;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .X     (x),
    .ready (ready),
    .done  (done),
    .result(result)
  );

  function automatic logic [31:0] ref_res(input logic [1:0] o,
                                          input int sh,
                                          input logic [31:0] xv);
    case (o)
      2'd0: return xv << sh;
      2'd1: return xv >> sh;
      2'd2: return $unsigned($signed(xv) >>> sh);
`ifdef SEQ_SHIFTER_ROR_EN
      default: return (sh == 0) ? xv : ((xv >> sh) | (xv << (32 - sh)));
`else
      default: return xv;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input int sh);
`ifndef SEQ_SHIFTER_ROR_EN
    if (o == 2'd3) return 1;
`endif
    return (sh + 3) / 4 + 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_op(input logic [1:0] o, input int sh,
                        input logic [31:0] xv, input bit spam);
    int cyc;
    bit seen;
    logic [31:0] exp;
    exp = ref_res(o, sh, xv);
    chk("ready_idle", {31'd0, ready}, 32'd1);
    start = 1'b1;
    op    = o;
    shamt = sh[4:0];
    x     = xv;
    @(negedge clk);
    start = spam;
    x     = spam ? 32'hFFFF_FFFF : 32'h0;
    op    = spam ? 2'd1 : 2'd0;
    shamt = spam ? 5'd7 : 5'd0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", cyc, ref_lat(o, sh));
    chk("result", result, exp);
    chk("ready_in_done", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("ready_back", {31'd0, ready}, 32'd1);
    chk("result_held", result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    shamt = 5'd0;
    x     = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'h0);

    run_op(2'd0, 2, 32'h0000_0003, 1'b0);
    run_op(2'd2, 31, 32'h8000_0000, 1'b0);
    run_op(2'd1, 31, 32'h8000_0000, 1'b0);
    run_op(2'd0, 0, 32'hDEAD_BEEF, 1'b0);
    run_op(2'd3, 1, 32'h0000_0001, 1'b0);
    run_op(2'd2, 4, 32'h7000_0000, 1'b0);
    run_op(2'd0, 5, 32'hA5A5_A5A5, 1'b0);

    // start held high throughout SHIFT/DONE must not launch a second op
    run_op(2'd1, 9, 32'h1234_5678, 1'b1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("spam_single_done", pulses, 0);

    // reset in the third SHIFT cycle of SRL 31
    start = 1'b1;
    op    = 2'd1;
    shamt = 5'd31;
    x     = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'h0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
